// File: rtl/crypto_sched.sv
// Request scheduler for the DES encrypt/decrypt engine pair: round-robin grant of two
// requesters, single-issue sequencing with a watchdog, and per-port response return.
module crypto_sched #(
    parameter int unsigned TIMEOUT = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key,
    input  logic        req0_vld,
    output logic        req0_rdy,
    input  logic [63:0] req0_data,
    input  logic        req0_mode,
    input  logic        req1_vld,
    output logic        req1_rdy,
    input  logic [63:0] req1_data,
    input  logic        req1_mode,
    output logic        rsp0_vld,
    input  logic        rsp0_rdy,
    output logic [63:0] rsp0_data,
    output logic        rsp0_err,
    output logic        rsp1_vld,
    input  logic        rsp1_rdy,
    output logic [63:0] rsp1_data,
    output logic        rsp1_err,
    output logic [63:0] eng_data,
    output logic [63:0] eng_key,
    output logic        enc_start,
    output logic        dec_start,
    input  logic [63:0] enc_result,
    input  logic [63:0] dec_result,
    input  logic        enc_result_vld,
    input  logic        dec_result_vld,
    output logic        busy
);

    localparam logic [5:0] TimeoutCnt = 6'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        gnt_id_q;
    logic        mode_q;
    logic [5:0]  wd_cnt_q;

    logic        grant0;
    logic        grant1;
    logic        sel_vld;
    logic        wait_done;
    logic [63:0] wait_res;
    logic        wait_err;
    logic        new_mode;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_vld && req1_vld) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
        end else begin
            grant0 = req0_vld;
            grant1 = req1_vld;
        end
    end

    assign req0_rdy = (state_q == StIdle) & grant0;
    assign req1_rdy = (state_q == StIdle) & grant1;
    assign new_mode = req1_rdy ? req1_mode : req0_mode;

    // Only the engine that was started may complete the operation.
    always_comb begin
        sel_vld   = mode_q ? dec_result_vld : enc_result_vld;
        wait_res  = '0;
        wait_err  = 1'b0;
        wait_done = 1'b0;
        if (sel_vld) begin
            wait_res  = mode_q ? dec_result : enc_result;
            wait_done = 1'b1;
        end else if (wd_cnt_q == TimeoutCnt) begin
            wait_err  = 1'b1;
            wait_done = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            gnt_id_q     <= 1'b0;
            mode_q       <= 1'b0;
            wd_cnt_q     <= '0;
            eng_data     <= '0;
            eng_key      <= '0;
            enc_start    <= 1'b0;
            dec_start    <= 1'b0;
            rsp0_vld     <= 1'b0;
            rsp0_data    <= '0;
            rsp0_err     <= 1'b0;
            rsp1_vld     <= 1'b0;
            rsp1_data    <= '0;
            rsp1_err     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req0_rdy || req1_rdy) begin
                        gnt_id_q     <= req1_rdy;
                        last_grant_q <= req1_rdy;
                        mode_q       <= new_mode;
                        eng_data     <= req1_rdy ? req1_data : req0_data;
                        eng_key      <= key;
                        enc_start    <= ~new_mode;
                        dec_start    <= new_mode;
                        busy         <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    enc_start <= 1'b0;
                    dec_start <= 1'b0;
                    wd_cnt_q  <= '0;
                    state_q   <= StWait;
                end
                StWait: begin
                    if (wait_done) begin
                        if (gnt_id_q) begin
                            rsp1_vld  <= 1'b1;
                            rsp1_data <= wait_res;
                            rsp1_err  <= wait_err;
                        end else begin
                            rsp0_vld  <= 1'b1;
                            rsp0_data <= wait_res;
                            rsp0_err  <= wait_err;
                        end
                        state_q <= StResp;
                    end else if (wd_cnt_q != '1) begin
                        wd_cnt_q <= wd_cnt_q + 6'd1;
                    end
                end
                StResp: begin
                    if ((rsp0_vld && rsp0_rdy) || (rsp1_vld && rsp1_rdy)) begin
                        rsp0_vld <= 1'b0;
                        rsp0_err <= 1'b0;
                        rsp1_vld <= 1'b0;
                        rsp1_err <= 1'b0;
                        busy     <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
